serial_add_ctrl: RTL and testbench

//   Bit-serial addition controller built around one full_adder cell (a,b,c -> sum,carry).

---
 rtl/serial_add_ctrl.sv | 160 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is reused WIDTH times, LSB first, with its carry
// fed back through a flop. Result and final carry are registered and held between adds.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns {carry, sum} of a single-bit full adder.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         fa_s;
    logic               last_bit_s;

    assign fa_s       = full_adder(a_sr_q[0], b_sr_q[0], c_q);
    assign last_bit_s = (cnt_q == CNT_W'(WIDTH - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            s_sr_q  <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADD;
                else       state_d = S_IDLE;
            end
            S_ADD: begin
                if (last_bit_s) state_d = S_DONE;
                else            state_d = S_ADD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, serial shifting and result capture.
    always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        s_sr_d = s_sr_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d = a_in;
                    b_sr_d = b_in;
                    s_sr_d = {WIDTH{1'b0}};
                    c_d    = cin;
                    cnt_d  = {CNT_W{1'b0}};
                end else begin
                    cnt_d  = cnt_q;
                end
            end
            S_ADD: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                s_sr_d = {fa_s[0], s_sr_q[WIDTH-1:1]};
                c_d    = fa_s[1];
                // Counter parks at zero after the last bit instead of wrapping.
                if (last_bit_s) begin
                    cnt_d  = {CNT_W{1'b0}};
                    sum_d  = {fa_s[0], s_sr_q[WIDTH-1:1]};
                    cout_d = fa_s[1];
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  cnt_d = cnt_q;
            default: cnt_d = {CNT_W{1'b0}};
        endcase
    end

    // Handshake outputs, decoded from the next state so they leave flops.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            S_ADD: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with hand-computed sums and latencies.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    int tests_run;
    int tests_failed;
    int done_cnt;
    int cyc;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits up to 30 edges for done; n = edges waited (0 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Applies start before an edge and returns after that edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic [8:0] exp);
        int n;
        launch(a, b, c);
        wait_done(n);
        check_eq({tag, "_latency"}, n, 32'd8);
        check_eq({tag, "_sum"}, {23'd0, cout, sum_out}, {23'd0, exp});
        @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int t0, t1, t2;
        logic [8:0] e6 [3];
        logic [7:0] a6 [3];
        logic [7:0] b6 [3];
        logic       c6 [3];
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        cyc          = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum", {23'd0, cout, sum_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1..T3
        run_add("t1", 8'h00, 8'h00, 1'b0, 9'h000);
        run_add("t2", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_add("t3", 8'hA5, 8'h5A, 1'b1, 9'h100);

        // T4: second start mid-ADD is ignored; previous result held during ADD
        d0 = done_cnt;
        launch(8'h3C, 8'h42, 1'b0);
        check_eq("t4_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        start = 1'b1;
        check_eq("t4_hold", {23'd0, cout, sum_out}, 32'h100);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check_eq("t4_latency", n, 32'd5);
        check_eq("t4_sum", {23'd0, cout, sum_out}, 32'h07E);
        repeat (12) @(posedge clk);
        #1;
        check_eq("t4_one_done", done_cnt - d0, 32'd1);
        check_eq("t4_idle", {31'd0, busy}, 32'd0);

        // T5: reset during an add
        d0 = done_cnt;
        launch(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_sum", {23'd0, cout, sum_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("t5_no_done", done_cnt - d0, 32'd0);
        run_add("t5_new", 8'h01, 8'h02, 1'b0, 9'h003);

        // T6: start held high, back-to-back adds
        a6[0] = 8'h12; b6[0] = 8'h34; c6[0] = 1'b0; e6[0] = 9'h046;
        a6[1] = 8'h80; b6[1] = 8'h80; c6[1] = 1'b1; e6[1] = 9'h101;
        a6[2] = 8'hFF; b6[2] = 8'h00; c6[2] = 1'b1; e6[2] = 9'h100;
        t0 = 0; t1 = 0; t2 = 0;
        @(negedge clk);
        a_in  = a6[0];
        b_in  = b6[0];
        cin   = c6[0];
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(n);
            check_eq($sformatf("t6_done%0d", i), {31'd0, done}, 32'd1);
            check_eq($sformatf("t6_sum%0d", i), {23'd0, cout, sum_out}, {23'd0, e6[i]});
            if (i == 0) t0 = cyc;
            else if (i == 1) t1 = cyc;
            else t2 = cyc;
            if (i < 2) begin
                a_in = a6[i+1];
                b_in = b6[i+1];
                cin  = c6[i+1];
            end
        end
        start = 1'b0;
        check_eq("t6_gap01", t1 - t0, 32'd10);
        check_eq("t6_gap12", t2 - t1, 32'd10);
        repeat (14) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
